calc_cmd_sequencer: RTL and testbench

- Front-end stage directly upstream of the registered calculator datapath (control/dataA/dataB input registers, ALU, result/carry registers, all gated by one enable).
- Receives a 3-byte command frame over a valid/ready byte stream (opcode, A, B) and drives the calculator's operand, control and enable inputs.
- Waits out the calculator's two-enable pipeline, captures result and carry, and returns them as a 2-byte response stream.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/calc_cmd_sequencer.sv | 136 +++++++++++++
 tb/tb_calc_cmd_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared state encoding and constants for the calculator command front-end
package calc_pkg;

    typedef enum logic [2:0] {
        S_OP  = 3'd0,
        S_A   = 3'd1,
        S_B   = 3'd2,
        S_EX1 = 3'd3,
        S_EX2 = 3'd4,
        S_CAP = 3'd5,
        S_TXR = 3'd6,
        S_TXC = 3'd7
    } calc_state_t;

    localparam logic [7:0] ERR_BYTE          = 8'hEE;
    localparam int         CALC_PIPE_ENABLES = 2;

    // Opcodes understood by the attached ALU
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_AND = 5'd2;
    localparam logic [4:0] OP_OR  = 5'd3;
    localparam logic [4:0] OP_XOR = 5'd4;
    localparam logic [4:0] OP_NOT = 5'd5;
    localparam logic [4:0] OP_SHL = 5'd6;
    localparam logic [4:0] OP_SHR = 5'd7;

endpackage

// File: rtl/calc_cmd_sequencer.sv
// rtl/calc_cmd_sequencer.sv - byte-stream command sequencer driving the registered calculator
// Optional opcode range check enabled by defining CALC_OPCHECK_EN.
module calc_cmd_sequencer
    import calc_pkg::*;
#(
    parameter int         WORD_LENGTH = 6,
    parameter logic [4:0] MAX_OPCODE  = 5'd15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   reset_sync,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [4:0]             calc_control,
    output logic [WORD_LENGTH-1:0] calc_dataA,
    output logic [WORD_LENGTH-1:0] calc_dataB,
    output logic                   calc_enable,
    input  logic [WORD_LENGTH-1:0] calc_result,
    input  logic [WORD_LENGTH-1:0] calc_carry,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy
);

`ifdef CALC_OPCHECK_EN
    localparam bit OPCHECK_ON = 1'b1;
`else
    localparam bit OPCHECK_ON = 1'b0;
`endif

    calc_state_t            state_q, state_d;
    logic [4:0]             ctrl_q;
    logic [WORD_LENGTH-1:0] a_q, b_q, res_q, carry_q;
    logic                   op_ld, a_ld, b_ld, cap;
    logic                   opcode_bad;
    logic                   rx_unused_bits;

    // Opcode bits above [4:0] and operand bits above WORD_LENGTH are dropped by design
    assign rx_unused_bits = &{1'b0, rx_data};

    assign opcode_bad = OPCHECK_ON && (ctrl_q > MAX_OPCODE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_OP;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= '0;
        end else if (reset_sync) begin
            state_q <= S_OP;
            ctrl_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= '0;
        end else begin
            state_q <= state_d;
            if (op_ld) ctrl_q <= rx_data[4:0];
            if (a_ld)  a_q    <= rx_data[WORD_LENGTH-1:0];
            if (b_ld)  b_q    <= rx_data[WORD_LENGTH-1:0];
            if (cap) begin
                res_q   <= calc_result;
                carry_q <= calc_carry;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rx_ready    = 1'b0;
        calc_enable = 1'b0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        op_ld       = 1'b0;
        a_ld        = 1'b0;
        b_ld        = 1'b0;
        cap         = 1'b0;
        case (state_q)
            S_OP: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    op_ld   = 1'b1;
                    state_d = S_A;
                end
            end
            S_A: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    a_ld    = 1'b1;
                    state_d = S_B;
                end
            end
            S_B: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    b_ld    = 1'b1;
                    // An out-of-range opcode bypasses the calculator entirely
                    state_d = opcode_bad ? S_TXR : S_EX1;
                end
            end
            S_EX1: begin
                calc_enable = 1'b1;
                state_d     = S_EX2;
            end
            S_EX2: begin
                calc_enable = 1'b1;
                state_d     = S_CAP;
            end
            S_CAP: begin
                cap     = 1'b1;
                state_d = S_TXR;
            end
            S_TXR: begin
                tx_valid = 1'b1;
                tx_data  = opcode_bad ? ERR_BYTE : 8'(res_q);
                if (tx_ready) state_d = S_TXC;
            end
            S_TXC: begin
                tx_valid = 1'b1;
                tx_data  = opcode_bad ? ERR_BYTE : 8'(carry_q);
                if (tx_ready) state_d = S_OP;
            end
            default: state_d = S_OP;
        endcase
    end

    assign calc_control = ctrl_q;
    assign calc_dataA   = a_q;
    assign calc_dataB   = b_q;
    assign busy         = (state_q != S_OP);

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb/tb_calc_cmd_sequencer.sv - directed self-checking bench for calc_cmd_sequencer
module tb_calc_cmd_sequencer;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         reset_sync = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_valid = 1'b0;
    logic         rx_ready;
    logic [4:0]   calc_control;
    logic [W-1:0] calc_dataA, calc_dataB;
    logic         calc_enable;
    logic [W-1:0] calc_result, calc_carry;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;
    int en_count = 0;
    int cyc = 0;
    logic [7:0] txq[$];

    always #5 clk = ~clk;

    calc_cmd_sequencer #(.WORD_LENGTH(W), .MAX_OPCODE(5'd15)) dut (
        .clk(clk), .reset(reset), .reset_sync(reset_sync),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .calc_control(calc_control), .calc_dataA(calc_dataA), .calc_dataB(calc_dataB),
        .calc_enable(calc_enable), .calc_result(calc_result), .calc_carry(calc_carry),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
    );

    // Calculator stub: input stage then result stage, both gated by calc_enable
    logic [W-1:0] stub_a = '0, stub_b = '0;
    logic [W:0]   stub_sum;
    assign stub_sum = {1'b0, stub_a} + {1'b0, stub_b};
    always @(posedge clk) begin
        if (calc_enable) begin
            stub_a      <= calc_dataA;
            stub_b      <= calc_dataB;
            calc_result <= stub_sum[W-1:0];
            calc_carry  <= W'(stub_sum[W]);
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (calc_enable) en_count = en_count + 1;
        if (tx_valid && tx_ready) txq.push_back(tx_data);
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (!rx_ready) begin
            n_bad++;
            $display("FAIL send_timeout: rx_ready=%0b required 1 for byte %h", rx_ready, b);
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h5A;
    endtask

    task automatic wait_resp(input int n, input string name, output logic [7:0] r0, output logic [7:0] r1);
        int t = 0;
        while (txq.size() < n && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (txq.size() < n) begin
            n_bad++;
            $display("FAIL %s_resp_count: got %0d bytes required %0d", name, txq.size(), n);
        end
        r0 = (txq.size() > 0) ? txq[0] : 8'hxx;
        r1 = (txq.size() > 1) ? txq[1] : 8'hxx;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp += 7;
        if (rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready: got %b required 1", rx_ready); end
        if (tx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_tx_valid: got %b required 0", tx_valid); end
        if (tx_data !== 8'h00) begin n_bad++; $display("FAIL reset_tx_data: got %h required 00", tx_data); end
        if (calc_enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable: got %b required 0", calc_enable); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (calc_control !== 5'd0) begin n_bad++; $display("FAIL reset_control: got %h required 00", calc_control); end
        if ({calc_dataA, calc_dataB} !== '0) begin n_bad++; $display("FAIL reset_data: got %h/%h required 0/0", calc_dataA, calc_dataB); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] r0, r1;
        int lat = 0;
        tx_ready = 1'b1;
        txq.delete();
        en_count = 0;
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h03);
        @(negedge clk);
        lat = 1;
        n_cmp += 2;
        if (calc_enable !== 1'b1) begin n_bad++; $display("FAIL basic_ex1_enable: got %b required 1", calc_enable); end
        if ({calc_dataA, calc_dataB} !== {6'd5, 6'd3}) begin n_bad++; $display("FAIL basic_operands: got %h/%h required 05/03", calc_dataA, calc_dataB); end
        while (!tx_valid && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== 4) begin n_bad++; $display("FAIL basic_latency: got %0d cycles required 4", lat); end
        wait_resp(2, "basic", r0, r1);
        @(negedge clk);
        n_cmp += 4;
        if (r0 !== 8'h08) begin n_bad++; $display("FAIL basic_result: got %h required 08", r0); end
        if (r1 !== 8'h00) begin n_bad++; $display("FAIL basic_carry: got %h required 00", r1); end
        if (en_count !== 2) begin n_bad++; $display("FAIL basic_enable_cycles: got %0d required 2", en_count); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_overflow();
        logic [7:0] r0, r1;
        txq.delete();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h01);
        n_cmp++;
        if (calc_dataA !== 6'h3F) begin n_bad++; $display("FAIL ovf_upper_bits: got %h required 3f", calc_dataA); end
        wait_resp(2, "ovf", r0, r1);
        n_cmp += 2;
        if (r0 !== 8'h00) begin n_bad++; $display("FAIL ovf_result: got %h required 00", r0); end
        if (r1 !== 8'h01) begin n_bad++; $display("FAIL ovf_carry: got %h required 01", r1); end
    endtask

    task automatic test_backpressure();
        logic [7:0] r0, r1;
        int t = 0;
        int bad_hold = 0;
        txq.delete();
        tx_ready = 1'b0;
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h03);
        while (!tx_valid && t < 12) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            rx_valid = i[0];
            rx_data  = 8'h1F;
            if (tx_data !== 8'h08 || tx_valid !== 1'b1 || rx_ready !== 1'b0) bad_hold++;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        n_cmp += 2;
        if (bad_hold !== 0) begin n_bad++; $display("FAIL bp_hold: got %0d unstable cycles required 0", bad_hold); end
        if (txq.size() !== 0) begin n_bad++; $display("FAIL bp_early_bytes: got %0d required 0", txq.size()); end
        tx_ready = 1'b1;
        wait_resp(2, "bp", r0, r1);
        n_cmp += 2;
        if (r0 !== 8'h08) begin n_bad++; $display("FAIL bp_result: got %h required 08", r0); end
        if (r1 !== 8'h00) begin n_bad++; $display("FAIL bp_carry: got %h required 00", r1); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] r0, r1;
        txq.delete();
        send_byte(8'h00);
        send_byte(8'h07);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp += 3;
        if (rx_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_ready_busy: got %b/%b required 1/0", rx_ready, busy); end
        if (calc_dataA !== 6'd0) begin n_bad++; $display("FAIL rstmid_dataA: got %h required 00", calc_dataA); end
        if (tx_valid !== 1'b0 || calc_enable !== 1'b0) begin n_bad++; $display("FAIL rstmid_outputs: got %b/%b required 0/0", tx_valid, calc_enable); end
        @(negedge clk);
        reset = 1'b1;
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h02);
        wait_resp(2, "rstmid", r0, r1);
        n_cmp += 2;
        if (r0 !== 8'h04) begin n_bad++; $display("FAIL rstmid_result: got %h required 04", r0); end
        if (r1 !== 8'h00) begin n_bad++; $display("FAIL rstmid_carry: got %h required 00", r1); end

        txq.delete();
        send_byte(8'h00);
        send_byte(8'h05);
        send_byte(8'h03);
        @(negedge clk);
        @(negedge clk);
        reset_sync = 1'b1;
        @(negedge clk);
        reset_sync = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || calc_dataA !== 6'd0) begin n_bad++; $display("FAIL rsync_clear: got busy=%b A=%h required 0/00", busy, calc_dataA); end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (txq.size() !== 0) begin n_bad++; $display("FAIL rsync_no_tx: got %0d bytes required 0", txq.size()); end
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h02);
        wait_resp(2, "rsync", r0, r1);
        n_cmp += 2;
        if (r0 !== 8'h03) begin n_bad++; $display("FAIL rsync_result: got %h required 03", r0); end
        if (r1 !== 8'h00) begin n_bad++; $display("FAIL rsync_carry: got %h required 00", r1); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r0, r1;
        int c_end1, c_op2;
        txq.delete();
        send_byte(8'h00);
        send_byte(8'h10);
        send_byte(8'h20);
        c_end1 = cyc;
        send_byte(8'h00);
        c_op2 = cyc;
        send_byte(8'h30);
        send_byte(8'h30);
        n_cmp++;
        if (c_op2 - c_end1 !== 6) begin n_bad++; $display("FAIL b2b_op_accept: got %0d cycles required 6", c_op2 - c_end1); end
        wait_resp(4, "b2b", r0, r1);
        n_cmp += 2;
        if ({r0, r1} !== 16'h3000) begin n_bad++; $display("FAIL b2b_frame1: got %h%h required 3000", r0, r1); end
        r0 = (txq.size() > 2) ? txq[2] : 8'hxx;
        r1 = (txq.size() > 3) ? txq[3] : 8'hxx;
        if ({r0, r1} !== 16'h2001) begin n_bad++; $display("FAIL b2b_frame2: got %h%h required 2001", r0, r1); end
    endtask

`ifdef CALC_OPCHECK_EN
    task automatic test_opcheck();
        logic [7:0] r0, r1;
        txq.delete();
        en_count = 0;
        send_byte(8'h1F);
        send_byte(8'h01);
        send_byte(8'h02);
        wait_resp(2, "opchk", r0, r1);
        n_cmp += 3;
        if ({r0, r1} !== 16'hEEEE) begin n_bad++; $display("FAIL opchk_err_bytes: got %h%h required eeee", r0, r1); end
        if (en_count !== 0) begin n_bad++; $display("FAIL opchk_enable: got %0d required 0", en_count); end
        if (calc_control !== 5'h1F) begin n_bad++; $display("FAIL opchk_latched: got %h required 1f", calc_control); end
        txq.delete();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h01);
        wait_resp(2, "opchk_legal", r0, r1);
        n_cmp += 2;
        if ({r0, r1} !== 16'h0200) begin n_bad++; $display("FAIL opchk_legal: got %h%h required 0200", r0, r1); end
        if (en_count !== 2) begin n_bad++; $display("FAIL opchk_legal_enable: got %0d required 2", en_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
`ifdef CALC_OPCHECK_EN
        test_opcheck();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
